// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl
//   Vending transaction controller. Validates incoming coins, keeps a 5-bit
//   running credit, and sequences COLLECT -> DISPENSE -> CHANGE. Cancel or an
//   inactivity timeout in COLLECT returns the credit through REFUND. All
//   handshakes with the dispenser and payout unit are level req/ack.
//
// Parameters
//   PRICE    item price in coin units (1..31)
//   TIMEOUT  idle cycles in COLLECT before an automatic refund (>= 1)
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_coin_valid    one-cycle strobe qualifying i_coin
//   i_coin          coin value (legal: 1, 2, 5, 10)
//   i_cancel        user cancel, level
//   i_dispense_ack  dispenser delivered the item
//   i_change_ack    payout unit took o_change_amt
//   o_total         accumulated credit
//   o_coin_reject   one-cycle pulse: last cycle's coin was refused
//   o_dispense_req  held high while waiting for i_dispense_ack
//   o_change_valid  held high while waiting for i_change_ack
//   o_change_amt    payout amount, stable while o_change_valid is high
//   o_refund        marks the current payout as a refund
//   o_busy          high in every state except IDLE
// ---------------------------------------------------------------------------
module vend_ctrl #(
    parameter logic [4:0]  PRICE   = 5'd15,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_coin_valid,
    input  logic [3:0] i_coin,
    input  logic       i_cancel,
    input  logic       i_dispense_ack,
    input  logic       i_change_ack,
    output logic [4:0] o_total,
    output logic       o_coin_reject,
    output logic       o_dispense_req,
    output logic       o_change_valid,
    output logic [4:0] o_change_amt,
    output logic       o_refund,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_total, w_total_nxt;
    logic [4:0]  r_change_amt, w_amt_nxt;
    logic [15:0] r_idle_cnt, w_cnt_nxt;
    logic        r_coin_reject, w_reject_nxt;
    logic        r_dispense_req, w_disp_nxt;
    logic        r_change_valid, w_cv_nxt;
    logic        r_refund, w_refund_nxt;
    logic        r_busy, w_busy_nxt;

    // Coin qualification
    logic       w_coin_legal;
    logic [5:0] w_sum;
    logic       w_fits;
    logic       w_open;
    logic       w_accept;
    logic       w_timeout;
    logic [4:0] w_change;

    assign w_coin_legal = (i_coin == 4'd1) || (i_coin == 4'd2) ||
                          (i_coin == 4'd5) || (i_coin == 4'd10);
    // 6-bit sum so an overflowing coin is caught rather than wrapping
    assign w_sum        = {1'b0, r_total} + {2'b00, i_coin};
    assign w_fits       = (w_sum <= 6'd31);
    assign w_open       = (r_state == S_IDLE) || (r_state == S_COLLECT);
    // A coin arriving together with cancel is refused so the refund amount
    // is exactly the credit held before that edge.
    assign w_accept     = i_coin_valid && w_coin_legal && w_fits && w_open && !i_cancel;
    assign w_timeout    = (r_idle_cnt == (TIMEOUT - 16'd1)) && !i_coin_valid;
    // Only evaluated in DISPENSE, where r_total >= PRICE is guaranteed
    assign w_change     = r_total - PRICE;

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_total        <= '0;
            r_change_amt   <= '0;
            r_idle_cnt     <= '0;
            r_coin_reject  <= 1'b0;
            r_dispense_req <= 1'b0;
            r_change_valid <= 1'b0;
            r_refund       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_total        <= w_total_nxt;
            r_change_amt   <= w_amt_nxt;
            r_idle_cnt     <= w_cnt_nxt;
            r_coin_reject  <= w_reject_nxt;
            r_dispense_req <= w_disp_nxt;
            r_change_valid <= w_cv_nxt;
            r_refund       <= w_refund_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (i_cancel)              w_state_nxt = S_REFUND;
                else if (r_total >= PRICE) w_state_nxt = S_DISPENSE;
                else if (w_timeout)        w_state_nxt = S_REFUND;
            end
            S_DISPENSE: begin
                if (i_dispense_ack)
                    w_state_nxt = (w_change != 5'd0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE, S_REFUND: begin
                if (i_change_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_total_nxt = r_total;
        w_amt_nxt   = r_change_amt;
        w_cnt_nxt   = '0;
        if (w_accept) w_total_nxt = w_sum[4:0];
        case (r_state)
            S_COLLECT: begin
                // any strobe counts as activity, even a refused coin
                w_cnt_nxt = i_coin_valid ? 16'd0 : r_idle_cnt + 16'd1;
                if (w_state_nxt == S_REFUND) w_amt_nxt = r_total;
            end
            S_DISPENSE: begin
                if (i_dispense_ack) begin
                    w_amt_nxt = w_change;
                    if (w_change == 5'd0) w_total_nxt = '0;
                end
            end
            S_CHANGE, S_REFUND: begin
                if (i_change_ack) w_total_nxt = '0;
            end
            default: ;
        endcase
        w_reject_nxt = i_coin_valid && !w_accept;
        w_disp_nxt   = (w_state_nxt == S_DISPENSE);
        w_cv_nxt     = (w_state_nxt == S_CHANGE) || (w_state_nxt == S_REFUND);
        w_refund_nxt = (w_state_nxt == S_REFUND);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
    end

    assign o_total        = r_total;
    assign o_coin_reject  = r_coin_reject;
    assign o_dispense_req = r_dispense_req;
    assign o_change_valid = r_change_valid;
    assign o_change_amt   = r_change_amt;
    assign o_refund       = r_refund;
    assign o_busy         = r_busy;

endmodule
